// File: rtl/id_stage_hazard.sv
// Instruction-decode stage with ID/EX pipeline register, register file with
// write-through bypass, load-use bubble insertion and a saturating stall counter.
module id_stage_hazard #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 16,
  localparam int RA_W    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      if_id_ir,
  input  logic [XLEN-1:0]  if_id_npc,
  input  logic             if_id_valid,
  input  logic             wb_reg_write,
  input  logic [RA_W-1:0]  wb_write_reg,
  input  logic [XLEN-1:0]  wb_write_data,
  input  logic             flush,
  input  logic             hold,
  output logic             stall_out,
  output logic [8:0]       id_ex_ctrl,
  output logic [XLEN-1:0]  id_ex_npc,
  output logic [XLEN-1:0]  id_ex_rs_data,
  output logic [XLEN-1:0]  id_ex_rt_data,
  output logic [XLEN-1:0]  id_ex_imm,
  output logic [RA_W-1:0]  id_ex_rs,
  output logic [RA_W-1:0]  id_ex_rt,
  output logic [RA_W-1:0]  id_ex_rd,
  output logic             id_ex_valid,
  output logic             illegal_op,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  localparam int CTRL_MEMREAD = 5;

  logic [5:0]      opcode;
  logic [RA_W-1:0] rs_addr;
  logic [RA_W-1:0] rt_addr;
  logic [RA_W-1:0] rd_addr;

  assign opcode  = if_id_ir[31:26];
  assign rs_addr = if_id_ir[21 +: RA_W];
  assign rt_addr = if_id_ir[16 +: RA_W];
  assign rd_addr = if_id_ir[11 +: RA_W];

  logic [8:0]      dec_ctrl;
  logic            dec_legal;
  logic            uses_rt;
  logic            zero_ext;
  logic [XLEN-1:0] dec_imm;

  // Control word layout: {RegWrite, MemtoReg, Branch, MemRead, MemWrite, RegDst, ALUOp[1:0], ALUSrc}
  always_comb begin
    dec_ctrl  = '0;
    dec_legal = 1'b1;
    uses_rt   = 1'b0;
    zero_ext  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec_ctrl = 9'b1_0_0_0_0_1_10_0;
        uses_rt  = 1'b1;
      end
      OP_LW:   dec_ctrl = 9'b1_1_0_1_0_0_00_1;
      OP_SW: begin
        dec_ctrl = 9'b0_0_0_0_1_0_00_1;
        uses_rt  = 1'b1;
      end
      OP_BEQ: begin
        dec_ctrl = 9'b0_0_1_0_0_0_01_0;
        uses_rt  = 1'b1;
      end
      OP_ADDI: dec_ctrl = 9'b1_0_0_0_0_0_00_1;
      OP_ANDI: begin
        dec_ctrl = 9'b1_0_0_0_0_0_11_1;
        zero_ext = 1'b1;
      end
      OP_ORI: begin
        dec_ctrl = 9'b1_0_0_0_0_0_11_1;
        zero_ext = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  assign dec_imm = zero_ext ? {{(XLEN-16){1'b0}}, if_id_ir[15:0]}
                            : {{(XLEN-16){if_id_ir[15]}}, if_id_ir[15:0]};

  logic [XLEN-1:0] regs [NREGS];
  logic            rf_write;

  assign rf_write = wb_reg_write && ((ZERO_REG == 0) || (wb_write_reg != '0));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (rf_write) begin
      regs[wb_write_reg] <= wb_write_data;
    end
  end

  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;

  // The zero-register override is applied last so a bypassed write to r0 still reads 0
  always_comb begin
    rs_val = regs[rs_addr];
    if (wb_reg_write && (wb_write_reg == rs_addr)) rs_val = wb_write_data;
    if ((ZERO_REG != 0) && (rs_addr == '0)) rs_val = '0;
  end

  always_comb begin
    rt_val = regs[rt_addr];
    if (wb_reg_write && (wb_write_reg == rt_addr)) rt_val = wb_write_data;
    if ((ZERO_REG != 0) && (rt_addr == '0)) rt_val = '0;
  end

  logic hazard;

  assign hazard = id_ex_valid && id_ex_ctrl[CTRL_MEMREAD] && if_id_valid &&
                  ((id_ex_rt == rs_addr) || (uses_rt && (id_ex_rt == rt_addr)));

  assign stall_out = hazard && !flush;

  // Data fields load on every non-hold edge; only the control/valid fields are squashed on flush or bubble
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_ex_ctrl    <= '0;
      id_ex_npc     <= '0;
      id_ex_rs_data <= '0;
      id_ex_rt_data <= '0;
      id_ex_imm     <= '0;
      id_ex_rs      <= '0;
      id_ex_rt      <= '0;
      id_ex_rd      <= '0;
      id_ex_valid   <= 1'b0;
      illegal_op    <= 1'b0;
      stall_count   <= '0;
    end else if (!hold) begin
      id_ex_npc     <= if_id_npc;
      id_ex_rs_data <= rs_val;
      id_ex_rt_data <= rt_val;
      id_ex_imm     <= dec_imm;
      id_ex_rs      <= rs_addr;
      id_ex_rt      <= rt_addr;
      id_ex_rd      <= rd_addr;
      if (flush) begin
        id_ex_ctrl  <= '0;
        id_ex_valid <= 1'b0;
        illegal_op  <= 1'b0;
      end else if (hazard) begin
        id_ex_ctrl  <= '0;
        id_ex_valid <= 1'b0;
        illegal_op  <= 1'b0;
        if (stall_count != '1) stall_count <= stall_count + 1'b1;
      end else begin
        id_ex_valid <= if_id_valid;
        id_ex_ctrl  <= if_id_valid ? dec_ctrl : 9'b0;
        illegal_op  <= if_id_valid && !dec_legal;
      end
    end
  end

endmodule

// File: tb/tb_id_stage_hazard.sv
// Bench for id_stage_hazard: directed scenarios then random traffic, all checked
// against a cycle-level reference model of the decode stage.
module tb_id_stage_hazard;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int RA_W  = 5;
  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic [31:0]      if_id_ir;
  logic [XLEN-1:0]  if_id_npc;
  logic             if_id_valid;
  logic             wb_reg_write;
  logic [RA_W-1:0]  wb_write_reg;
  logic [XLEN-1:0]  wb_write_data;
  logic             flush;
  logic             hold;
  logic             stall_out;
  logic [8:0]       id_ex_ctrl;
  logic [XLEN-1:0]  id_ex_npc;
  logic [XLEN-1:0]  id_ex_rs_data;
  logic [XLEN-1:0]  id_ex_rt_data;
  logic [XLEN-1:0]  id_ex_imm;
  logic [RA_W-1:0]  id_ex_rs;
  logic [RA_W-1:0]  id_ex_rt;
  logic [RA_W-1:0]  id_ex_rd;
  logic             id_ex_valid;
  logic             illegal_op;
  logic [CNT_W-1:0] stall_count;

  id_stage_hazard #(
    .XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .if_id_ir(if_id_ir), .if_id_npc(if_id_npc), .if_id_valid(if_id_valid),
    .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
    .flush(flush), .hold(hold), .stall_out(stall_out),
    .id_ex_ctrl(id_ex_ctrl), .id_ex_npc(id_ex_npc),
    .id_ex_rs_data(id_ex_rs_data), .id_ex_rt_data(id_ex_rt_data), .id_ex_imm(id_ex_imm),
    .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd),
    .id_ex_valid(id_ex_valid), .illegal_op(illegal_op), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_regs [NREGS];
  logic [8:0]  m_ctrl;
  logic        m_valid, m_illegal, m_loaded;
  logic [31:0] m_npc, m_rs_data, m_rt_data, m_imm;
  logic [4:0]  m_rs, m_rt, m_rd;
  int          m_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {legal, uses_rt, zero_ext, ctrl[8:0]} from the opcode table
  function automatic logic [11:0] opcode_info(input logic [5:0] op);
    case (op)
      6'h00:   return {3'b110, 9'h10C};
      6'h23:   return {3'b100, 9'b1_1_0_1_0_0_00_1};
      6'h2B:   return {3'b110, 9'b0_0_0_0_1_0_00_1};
      6'h04:   return {3'b110, 9'b0_0_1_0_0_0_01_0};
      6'h08:   return {3'b100, 9'b1_0_0_0_0_0_00_1};
      6'h0C:   return {3'b101, 9'b1_0_0_0_0_0_11_1};
      6'h0D:   return {3'b101, 9'b1_0_0_0_0_0_11_1};
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (wb_reg_write && wb_write_reg == a) return wb_write_data;
    return m_regs[a];
  endfunction

  function automatic logic model_hazard();
    logic [11:0] info;
    info = opcode_info(if_id_ir[31:26]);
    return m_valid && m_ctrl[5] && if_id_valid &&
           (m_rt == if_id_ir[25:21] || (info[10] && m_rt == if_id_ir[20:16]));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = 32'h0;
    m_ctrl = 0; m_valid = 0; m_illegal = 0; m_loaded = 1;
    m_npc = 0; m_rs_data = 0; m_rt_data = 0; m_imm = 0;
    m_rs = 0; m_rt = 0; m_rd = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    logic [11:0] info;
    logic        hz;
    info = opcode_info(if_id_ir[31:26]);
    hz = model_hazard();
    if (!hold) begin
      m_npc     = if_id_npc;
      m_rs_data = model_read(if_id_ir[25:21]);
      m_rt_data = model_read(if_id_ir[20:16]);
      m_imm     = info[9] ? {16'h0, if_id_ir[15:0]} : {{16{if_id_ir[15]}}, if_id_ir[15:0]};
      m_rs = if_id_ir[25:21]; m_rt = if_id_ir[20:16]; m_rd = if_id_ir[15:11];
      if (flush || hz) begin
        m_ctrl = 0; m_valid = 0; m_illegal = 0; m_loaded = 0;
        if (!flush && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      end else begin
        m_valid   = if_id_valid;
        m_ctrl    = if_id_valid ? info[8:0] : 9'h0;
        m_illegal = if_id_valid && !info[11];
        m_loaded  = 1;
      end
    end
    if (wb_reg_write && wb_write_reg != 0) m_regs[wb_write_reg] = wb_write_data;
  endtask

  task automatic apply_stimulus(input string tag, input logic [31:0] ir, input logic [31:0] npc,
                                input logic iv, input logic we, input logic [4:0] wr,
                                input logic [31:0] wd, input logic fl, input logic hd);
    @(negedge clk);
    if_id_ir = ir; if_id_npc = npc; if_id_valid = iv;
    wb_reg_write = we; wb_write_reg = wr; wb_write_data = wd;
    flush = fl; hold = hd;
    #1;
    check({tag, ".stall_out"}, stall_out, model_hazard() && !fl);
  endtask

  task automatic check_output(input string tag);
    check({tag, ".valid"}, id_ex_valid, m_valid);
    check({tag, ".ctrl"}, id_ex_ctrl, m_ctrl);
    check({tag, ".illegal"}, illegal_op, m_illegal);
    check({tag, ".count"}, stall_count, m_cnt);
    if (m_loaded) begin
      check({tag, ".npc"}, id_ex_npc, m_npc);
      check({tag, ".rs_data"}, id_ex_rs_data, m_rs_data);
      check({tag, ".rt_data"}, id_ex_rt_data, m_rt_data);
      check({tag, ".imm"}, id_ex_imm, m_imm);
      check({tag, ".rs"}, id_ex_rs, m_rs);
      check({tag, ".rt"}, id_ex_rt, m_rt);
      check({tag, ".rd"}, id_ex_rd, m_rd);
    end
  endtask

  task automatic run_cycle(input string tag, input logic [31:0] ir, input logic [31:0] npc,
                           input logic iv, input logic we, input logic [4:0] wr,
                           input logic [31:0] wd, input logic fl, input logic hd);
    apply_stimulus(tag, ir, npc, iv, we, wr, wd, fl, hd);
    @(posedge clk);
    model_step();
    #1;
    check_output(tag);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".ctrl"}, id_ex_ctrl, 9'h0);
    check({tag, ".valid"}, id_ex_valid, 1'b0);
    check({tag, ".illegal"}, illegal_op, 1'b0);
    check({tag, ".count"}, stall_count, 4'h0);
    check({tag, ".npc"}, id_ex_npc, 32'h0);
    check({tag, ".rs_data"}, id_ex_rs_data, 32'h0);
    check({tag, ".rt"}, id_ex_rt, 5'h0);
    check({tag, ".stall_out"}, stall_out, 1'b0);
  endtask

  function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 11'h020};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  initial begin
    logic [5:0] ops [8];
    int         saved_cnt;
    logic [5:0] op;
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h3F};

    reset = 1'b0;
    if_id_ir = 0; if_id_npc = 0; if_id_valid = 0;
    wb_reg_write = 0; wb_write_reg = 0; wb_write_data = 0;
    flush = 0; hold = 0;
    model_reset();
    #3;
    check_reset_state("reset");
    @(negedge clk);
    reset = 1'b1;

    // Seed a few registers
    run_cycle("init1", 32'h0, 32'h0, 1'b0, 1'b1, 5'd1, 32'h1111_0001, 1'b0, 1'b0);
    run_cycle("init2", 32'h0, 32'h0, 1'b0, 1'b1, 5'd2, 32'h2222_0002, 1'b0, 1'b0);

    // Same-cycle write-through bypass, and r0 ignoring writes
    run_cycle("bypass", mk_r(5'd5, 5'd2, 5'd6), 32'h100, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0);
    check("bypass.const", id_ex_rs_data, 32'hDEADBEEF);
    run_cycle("r0_write", mk_r(5'd0, 5'd5, 5'd6), 32'h104, 1'b1, 1'b1, 5'd0, 32'h1234_5678, 1'b0, 1'b0);
    check("r0_write.const", id_ex_rs_data, 32'h0);

    // Load-use on rs: one bubble, then the add enters with R-type control
    run_cycle("lu_lw", mk_i(6'h23, 5'd1, 5'd3, 16'h0004), 32'h108, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    run_cycle("lu_stall", mk_r(5'd3, 5'd2, 5'd4), 32'h10C, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    check("lu_stall.count_const", stall_count, 4'd1);
    check("lu_stall.valid_const", id_ex_valid, 1'b0);
    run_cycle("lu_pass", mk_r(5'd3, 5'd2, 5'd4), 32'h10C, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    check("lu_pass.ctrl_const", id_ex_ctrl, 9'h10C);

    // addi does not read rt, sw does
    run_cycle("rt_lw", mk_i(6'h23, 5'd1, 5'd3, 16'h0008), 32'h110, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    run_cycle("rt_addi", mk_i(6'h08, 5'd1, 5'd3, 16'h0001), 32'h114, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    check("rt_addi.valid_const", id_ex_valid, 1'b1);
    run_cycle("rt_lw2", mk_i(6'h23, 5'd1, 5'd3, 16'h0008), 32'h118, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    run_cycle("rt_sw", mk_i(6'h2B, 5'd1, 5'd3, 16'h0000), 32'h11C, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    check("rt_sw.count_const", stall_count, 4'd2);

    // Flush overrides the hazard and leaves the counter alone
    run_cycle("fl_lw", mk_i(6'h23, 5'd1, 5'd3, 16'h0008), 32'h120, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    saved_cnt = m_cnt;
    run_cycle("fl_add", mk_r(5'd3, 5'd2, 5'd4), 32'h124, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    check("fl_add.count_const", stall_count, saved_cnt);

    // Immediate extension and illegal opcode
    run_cycle("andi", mk_i(6'h0C, 5'd1, 5'd7, 16'h8001), 32'h128, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    check("andi.imm_const", id_ex_imm, 32'h0000_8001);
    run_cycle("addi", mk_i(6'h08, 5'd1, 5'd7, 16'h8001), 32'h12C, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    check("addi.imm_const", id_ex_imm, 32'hFFFF_8001);
    run_cycle("illegal", mk_i(6'h3F, 5'd1, 5'd7, 16'h0000), 32'h130, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    check("illegal.const", illegal_op, 1'b1);

    // Hold freezes ID/EX but WB writes still land
    for (int i = 0; i < 3; i++)
      run_cycle("hold", mk_r(5'd9, 5'd9, 5'd1), 32'h200 + i, 1'b1, 1'b1, 5'd9 + i, 32'hA0 + i, 1'b0, 1'b1);
    check("hold.illegal_const", illegal_op, 1'b1);
    run_cycle("after_hold", mk_r(5'd9, 5'd10, 5'd1), 32'h204, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    check("after_hold.rs_const", id_ex_rs_data, 32'hA0);

    // Reset asserted while a stall is pending
    run_cycle("rst_lw", mk_i(6'h23, 5'd1, 5'd3, 16'h0008), 32'h300, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    apply_stimulus("rst_add", mk_r(5'd3, 5'd2, 5'd4), 32'h304, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    check("rst_add.stall_const", stall_out, 1'b1);
    #1 reset = 1'b0;
    #1;
    model_reset();
    check_reset_state("rst_mid");
    @(negedge clk);
    reset = 1'b1;

    // Counter saturation with the narrow bench counter
    for (int i = 0; i < 17; i++) begin
      run_cycle("sat_lw", mk_i(6'h23, 5'd1, 5'd3, 16'h0000), 32'h400, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
      run_cycle("sat_stall", mk_r(5'd3, 5'd2, 5'd4), 32'h404, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
      run_cycle("sat_pass", mk_r(5'd3, 5'd2, 5'd4), 32'h404, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    end
    check("sat.count_const", stall_count, 4'hF);

    // Random traffic with small register indices to provoke hazards
    for (int i = 0; i < 400; i++) begin
      op = ops[$urandom_range(0, 7)];
      if (op == 6'h3F) op = 6'($urandom);
      run_cycle("rand",
                {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)},
                $urandom, ($urandom_range(0, 7) != 0), 1'($urandom),
                5'($urandom_range(0, 7)), $urandom,
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_stage_hazard.md
Name: id_stage_hazard

Overview:
Parametrised instruction-decode stage with an integrated ID/EX pipeline register. It adds load-use hazard detection with bubble insertion, write-through register-file bypass, flush and hold controls, and per-opcode immediate extension. It also keeps a saturating stall counter. It sits between the IF/ID latch and the EX stage, and receives write-back from the MEM/WB stage.

Parameters:
XLEN, 32, datapath width (instruction width is fixed at 32)
NREGS, 32, number of architectural registers (power of 2, ≥2); RA_W = log2(NREGS), at most 5
ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes
CNT_W, 16, width of the stall performance counter

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
if_id_ir  in  32  instruction from IF/ID
if_id_npc  in  XLEN  next PC from IF/ID
if_id_valid  in  1  IF/ID holds a real instruction
wb_reg_write  in  1  write enable from WB
wb_write_reg  in  RA_W  WB destination register
wb_write_data  in  XLEN  WB data
flush  in  1  branch taken; squash the instruction entering ID/EX
hold  in  1  global freeze; ID/EX and counter retain state
stall_out  out  1  combinational; freeze PC and IF/ID
id_ex_ctrl  out  9  {RegWrite, MemtoReg, Branch, MemRead, MemWrite, RegDst, ALUOp[1:0], ALUSrc}
id_ex_npc  out  XLEN  latched NPC
id_ex_rs_data  out  XLEN  latched rs value
id_ex_rt_data  out  XLEN  latched rt value
id_ex_imm  out  XLEN  latched extended immediate
id_ex_rs  out  RA_W  latched ir[25:21] (for forwarding)
id_ex_rt  out  RA_W  latched ir[20:16]
id_ex_rd  out  RA_W  latched ir[15:11]
id_ex_valid  out  1  ID/EX holds a real instruction
illegal_op  out  1  registered; a valid unknown opcode entered ID/EX
stall_count  out  CNT_W  saturating count of load-use bubbles

Behaviour:
- Reset (reset=0, asynchronous): all id_ex_* outputs, illegal_op and stall_count go to 0. All registers in the file go to 0.
- Decode is combinational on ir[31:26]. Control values:
  - R-type 0x00: 1_0_0_0_0_1_10_0
  - lw 0x23: 1_1_0_1_0_0_00_1
  - sw 0x2B: 0_0_0_0_1_0_00_1
  - beq 0x04: 0_0_1_0_0_0_01_0
  - addi 0x08: 1_0_0_0_0_0_00_1
  - andi 0x0C: 1_0_0_0_0_0_11_1
  - ori 0x0D: 1_0_0_0_0_0_11_1
  - Any other opcode: ctrl = 0 and illegal flagged.
- Immediate: andi and ori zero-extend ir[15:0] to XLEN. All other opcodes sign-extend.
- Register addressing: register address fields use the low RA_W bits of each 5-bit instruction field.
- Register file:
  - Write on the rising edge when wb_reg_write=1 (and, if ZERO_REG=1, wb_write_reg≠0).
  - Reads are combinational.
  - Bypass: if the write is enabled and wb_write_reg equals a read address, the read returns wb_write_data in the same cycle.
  - Register 0 always reads 0 when ZERO_REG=1, even when bypassed.
- Load-use hazard: uses_rt = R-type, sw or beq. The hazard term is: id_ex_valid & id_ex_ctrl[MemRead] & if_id_valid & (id_ex_rt==ir rs | (uses_rt & id_ex_rt==ir rt)).
- stall_out = hazard & ~flush. Flush overrides the stall because the dependent instruction is being squashed.
- ID/EX update on the rising edge, in priority order:
  1. hold=1: all state retained; stall_count does not increment.
  2. flush=1: ctrl=0, valid=0, illegal_op=0. The data fields may load.
  3. hazard: bubble (ctrl=0, valid=0, illegal_op=0); stall_count += 1, saturating at all-ones.
  4. Otherwise load decoded values:
     - valid = if_id_valid
     - ctrl = decoded ctrl if if_id_valid, else 0
     - illegal_op = if_id_valid & unknown opcode
- Latency: one cycle from IF/ID to ID/EX. A stall lasts exactly one cycle per load-use pair, because the bubble clears the hazard term on the next cycle.
- The WB write still happens while hold or stall is active.
- Reset asserted mid-stall clears all state immediately. stall_out then deasserts because id_ex_valid=0.

Test Plan:
- Write/bypass: WB writes r5=0xDEADBEEF while the instruction reads rs=5 in the same cycle → id_ex_rs_data=0xDEADBEEF next edge. A write to r0 → r0 still reads 0.
- Load-use: lw r3 then add r4,r3,r2 → stall_out=1 for one cycle; ID/EX ctrl=0 and valid=0 for one cycle; stall_count goes 0→1. The add then enters ID/EX with ctrl=0x10C.
- Rt-only hazard: lw r3 then addi r3,r3? use addi r7,r1,… with rt=3 → no stall, since addi does not use rt. sw with rt=3 after lw r3 → stall.
- Flush with hazard: lw r3, then add using r3 with flush=1 → stall_out=0; next ID/EX valid=0, ctrl=0; stall_count unchanged.
- Extension and illegal: andi imm 0x8001 → id_ex_imm=0x00008001. addi imm 0x8001 → 0xFFFF8001. Opcode 0x3F valid → illegal_op=1 and ctrl=0.
- Hold and reset: hold=1 for 3 cycles → outputs frozen while the register write still lands. Assert reset low mid-stall → all outputs 0 asynchronously; stall_count=0.
